// File: rtl/bcsa16_err_monitor.sv
`default_nettype none
// ============================================================================
// Module   : bcsa16_err_monitor
// Brief    : Windowed error statistics for the 16-bit approximate block
//            carry-select adder (error count, summed/max error distance).
//            Optional signed bias accumulator: define BCSA_ERRMON_BIAS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bcsa16_err_monitor #(
    parameter int WINDOW = 256,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    input  logic [16:0]      sum_apx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] samples,
    output logic [CNT_W-1:0] err_count,
    output logic [31:0]      ed_sum,
    output logic [16:0]      ed_max
`ifdef BCSA_ERRMON_BIAS_EN
    ,
    output logic signed [32:0] bias_sum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WINDOW - 1);

    state_t            r_state;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_samples;
    logic [CNT_W-1:0]  r_err_count;
    logic [31:0]       r_ed_sum;
    logic [16:0]       r_ed_max;
    logic [16:0]       r_exact;
    logic [16:0]       r_apx;
    logic              r_s1_valid;

    logic              w_xfer;
    logic              w_clear;
    logic [16:0]       w_ed;
    logic [32:0]       w_ed_sum_ext;

    assign w_xfer  = in_valid && r_in_ready;
    assign w_clear = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    assign w_ed         = (r_exact >= r_apx) ? (r_exact - r_apx) : (r_apx - r_exact);
    assign w_ed_sum_ext = {1'b0, r_ed_sum} + {16'd0, w_ed};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_xfer && (r_samples == C_LAST)) begin
                        r_state    <= S_DRAIN;
                        r_in_ready <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture exact and approximate sums on each transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exact    <= 17'd0;
            r_apx      <= 17'd0;
            r_s1_valid <= 1'b0;
            r_samples  <= '0;
        end else begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_exact <= {1'b0, a} + {1'b0, b};
                r_apx   <= sum_apx;
            end
            if (w_clear) begin
                r_samples <= '0;
            end else if (w_xfer) begin
                r_samples <= r_samples + CNT_W'(1);
            end
        end
    end

    // Stage 2: fold error distance into the window statistics. s1_valid is
    // never set while a window can be cleared, so the two never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
            r_ed_sum    <= 32'd0;
            r_ed_max    <= 17'd0;
        end else if (w_clear) begin
            r_err_count <= '0;
            r_ed_sum    <= 32'd0;
            r_ed_max    <= 17'd0;
        end else if (r_s1_valid) begin
            if (w_ed != 17'd0) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
            r_ed_sum <= w_ed_sum_ext[32] ? 32'hFFFF_FFFF : w_ed_sum_ext[31:0];
            if (w_ed > r_ed_max) begin
                r_ed_max <= w_ed;
            end
        end
    end

`ifdef BCSA_ERRMON_BIAS_EN
    logic signed [32:0] r_bias_sum;
    logic        [17:0] w_diff;

    assign w_diff = {1'b0, r_apx} - {1'b0, r_exact};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bias_sum <= 33'sd0;
        end else if (w_clear) begin
            r_bias_sum <= 33'sd0;
        end else if (r_s1_valid) begin
            r_bias_sum <= r_bias_sum + $signed({{15{w_diff[17]}}, w_diff});
        end
    end

    assign bias_sum = r_bias_sum;
`endif

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign samples   = r_samples;
    assign err_count = r_err_count;
    assign ed_sum    = r_ed_sum;
    assign ed_max    = r_ed_max;

endmodule
`default_nettype wire

// File: tb/tb_bcsa16_err_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcsa16_err_monitor
// Brief    : Directed self-checking bench for bcsa16_err_monitor, WINDOW=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcsa16_err_monitor;

    localparam int WINDOW = 4;
    localparam int CNT_W  = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      a;
    logic [15:0]      b;
    logic [16:0]      sum_apx;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] samples;
    logic [CNT_W-1:0] err_count;
    logic [31:0]      ed_sum;
    logic [16:0]      ed_max;
`ifdef BCSA_ERRMON_BIAS_EN
    logic signed [32:0] bias_sum;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int n_xfer = 0;

    bcsa16_err_monitor #(
        .WINDOW (WINDOW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sum_apx   (sum_apx),
        .busy      (busy),
        .done      (done),
        .samples   (samples),
        .err_count (err_count),
        .ed_sum    (ed_sum),
        .ed_max    (ed_max)
`ifdef BCSA_ERRMON_BIAS_EN
        ,
        .bias_sum  (bias_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [16:0] s);
        a        = x;
        b        = y;
        sum_apx  = s;
        in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_win();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        a = 16'd0; b = 16'd0; sum_apx = 17'd0;
        @(negedge clk);
        chk("rst_in_ready", 33'(in_ready), 33'd0);
        chk("rst_busy",     33'(busy),     33'd0);
        chk("rst_done",     33'(done),     33'd0);
        chk("rst_samples",  33'(samples),  33'd0);
        chk("rst_ed_max",   33'(ed_max),   33'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 33'(in_ready), 33'd0);

        // Window 1: four exact samples.
        start_win();
        chk("w1_in_ready", 33'(in_ready), 33'd1);
        chk("w1_busy",     33'(busy),     33'd1);
        repeat (4) send(16'h1234, 16'h0F0F, 17'h02143);
        in_valid = 1'b0;
        chk("w1_drain_ready", 33'(in_ready), 33'd0);
        chk("w1_drain_busy",  33'(busy),     33'd1);
        chk("w1_drain_done",  33'(done),     33'd0);
        @(negedge clk);
        chk("w1_done",      33'(done),      33'd1);
        chk("w1_samples",   33'(samples),   33'd4);
        chk("w1_err_count", 33'(err_count), 33'd0);
        chk("w1_ed_sum",    33'(ed_sum),    33'd0);
        chk("w1_ed_max",    33'(ed_max),    33'd0);
        chk("w1_done_busy", 33'(busy),      33'd0);
        @(negedge clk);
        chk("w1_done_pulse", 33'(done),    33'd0);
        chk("w1_hold",       33'(samples), 33'd4);

        // Window 2: one missed-carry sample among exact ones.
        start_win();
        chk("w2_cleared", 33'(samples), 33'd0);
        send(16'h0040, 16'h00C0, 17'h00000);
        chk("w2_lat_samples", 33'(samples),   33'd1);
        chk("w2_lat_err",     33'(err_count), 33'd0);
        send(16'h0001, 16'h0002, 17'h00003);
        chk("w2_err_after1", 33'(err_count), 33'd1);
        send(16'hFFFF, 16'h0001, 17'h10000);
        send(16'h8000, 16'h8000, 17'h10000);
        in_valid = 1'b0;
        @(negedge clk);
        chk("w2_done",      33'(done),      33'd1);
        chk("w2_err_count", 33'(err_count), 33'd1);
        chk("w2_ed_sum",    33'(ed_sum),    33'd256);
        chk("w2_ed_max",    33'(ed_max),    33'h00100);
`ifdef BCSA_ERRMON_BIAS_EN
        chk("w2_bias", 33'(bias_sum), 33'h1_FFFF_FF00);
`endif
        @(negedge clk);

        // Window 3: approx above exact, restart from the done cycle.
        start_win();
        send(16'h0001, 16'h0001, 17'h1FFFF);
        send(16'hFFFF, 16'hFFFF, 17'h1FFFE);
        send(16'h0000, 16'h0000, 17'h00000);
        send(16'h00FF, 16'h0001, 17'h00100);
        in_valid = 1'b0;
        @(negedge clk);
        chk("w3_done",      33'(done),      33'd1);
        chk("w3_err_count", 33'(err_count), 33'd1);
        chk("w3_ed_max",    33'(ed_max),    33'h1FFFD);
        chk("w3_ed_sum",    33'(ed_sum),    33'h0001FFFD);
`ifdef BCSA_ERRMON_BIAS_EN
        chk("w3_bias", 33'(bias_sum), 33'h0_0001_FFFD);
`endif
        start = 1'b1;
        @(negedge clk);
        chk("w4_rerun_ready", 33'(in_ready), 33'd1);
        chk("w4_rerun_busy",  33'(busy),     33'd1);
        chk("w4_rerun_done",  33'(done),     33'd0);
        chk("w4_clr_samples", 33'(samples),  33'd0);
        chk("w4_clr_ed_max",  33'(ed_max),   33'd0);
        chk("w4_clr_ed_sum",  33'(ed_sum),   33'd0);

        // Window 4: in_valid held for six cycles, start held early in RUN.
        for (int i = 0; i < 6; i++) begin
            if (in_ready) n_xfer++;
            send(16'(i), 16'h0010, 17'(i + 16));
            if (i == 1) start = 1'b0;
            if (i == 1) chk("w4_start_ignored", 33'(samples), 33'd2);
            if (i == 3) chk("w4_ready_low", 33'(in_ready), 33'd0);
            if (i == 4) chk("w4_done", 33'(done), 33'd1);
        end
        in_valid = 1'b0;
        chk("w4_xfers",   33'(n_xfer),    33'd4);
        chk("w4_samples", 33'(samples),   33'd4);
        chk("w4_err",     33'(err_count), 33'd0);
        chk("w4_idle",    33'(busy),      33'd0);

        // Window 5: asynchronous reset mid-window.
        start_win();
        send(16'h0040, 16'h00C0, 17'h00000);
        send(16'h0001, 16'h0002, 17'h00003);
        in_valid = 1'b0;
        chk("w5_pre_samples", 33'(samples),   33'd2);
        chk("w5_pre_err",     33'(err_count), 33'd1);
        #2 rst = 1'b1;
        #1;
        chk("w5_rst_ready",   33'(in_ready),  33'd0);
        chk("w5_rst_busy",    33'(busy),      33'd0);
        chk("w5_rst_samples", 33'(samples),   33'd0);
        chk("w5_rst_err",     33'(err_count), 33'd0);
        chk("w5_rst_ed_sum",  33'(ed_sum),    33'd0);
        chk("w5_rst_ed_max",  33'(ed_max),    33'd0);
`ifdef BCSA_ERRMON_BIAS_EN
        chk("w5_rst_bias", 33'(bias_sum), 33'd0);
`endif
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("w5_no_done",  33'(done),     33'd0);
            chk("w5_idle_rdy", 33'(in_ready), 33'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
